// File: rtl/axi4_w_burst_reader_pkg.sv
// Shared types and constants for the W-channel burst reader.
// Used by the interface, the output stage and the top-level FSM.
package axi4_w_reader_pkg;

    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned DEF_LEN_W    = 8;
    // dat_d packs {strb, data}: data occupies the LSBs, strb starts right above it
    localparam int unsigned DAT_DATA_LSB = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic int unsigned dat_strb_lsb(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/axi4_w_burst_reader_if.sv
// FIFO-pop and AXI4 W-channel signal bundle of the burst reader.
// The master modport is the reader's view; slave is the surrounding fabric.
interface axi4_w_burst_reader_if
    import axi4_w_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned STRB_W = DATA_W / 8,
    parameter int unsigned LEN_W  = DEF_LEN_W
);
    logic [LEN_W-1:0]         cmd_len;
    logic                     cmd_empty_n;
    logic                     cmd_deq;
    logic [DATA_W+STRB_W-1:0] dat_d;
    logic                     dat_empty_n;
    logic                     dat_deq;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic                     w_last;
    logic                     w_valid;
    logic                     w_ready;
    logic                     busy;

    modport master (
        input  cmd_len, cmd_empty_n, dat_d, dat_empty_n, w_ready,
        output cmd_deq, dat_deq, w_data, w_strb, w_last, w_valid, busy
    );

    modport slave (
        output cmd_len, cmd_empty_n, dat_d, dat_empty_n, w_ready,
        input  cmd_deq, dat_deq, w_data, w_strb, w_last, w_valid, busy
    );
endinterface

// File: rtl/axi4_w_burst_reader_chk.sv
// Protocol checks for the burst reader: no pop of an empty FIFO and
// no withdrawal of WVALID before the slave has taken the beat.
module axi4_w_burst_reader_chk (
    input logic CLK,
    input logic RST,
    input logic cmd_deq_i,
    input logic cmd_empty_n_i,
    input logic dat_deq_i,
    input logic dat_empty_n_i,
    input logic w_valid_i,
    input logic w_ready_i
);
    a_cmd_pop_nonempty: assert property (@(posedge CLK) disable iff (RST)
        cmd_deq_i |-> cmd_empty_n_i);

    a_dat_pop_nonempty: assert property (@(posedge CLK) disable iff (RST)
        dat_deq_i |-> dat_empty_n_i);

    a_valid_held: assert property (@(posedge CLK) disable iff (RST)
        (!$past(RST) && $past(w_valid_i) && !$past(w_ready_i)) |-> w_valid_i);
endmodule

// File: rtl/axi4_w_burst_reader_out_stage.sv
// Single valid/ready output register for the W channel.
// Loads a new beat whenever the register is empty or its beat is being taken.
module axi4_w_out_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [STRB_W-1:0] strb_i,
    input  logic              last_i,
    input  logic              w_ready_i,
    output logic              can_load_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic [STRB_W-1:0] w_strb_o,
    output logic              w_last_o,
    output logic              w_valid_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    assign can_load_o = !valid_q || w_ready_i;

    // Next beat: load, drain to idle, or hold while the slave stalls
    always_comb begin
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (can_load_o) begin
            if (load_i) begin
                data_d  = data_i;
                strb_d  = strb_i;
                last_d  = last_i;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= {DATA_W{1'b0}};
            strb_q  <= {STRB_W{1'b0}};
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign w_data_o  = data_q;
    assign w_strb_o  = strb_q;
    assign w_last_o  = last_q;
    assign w_valid_o = valid_q;
endmodule

// File: rtl/axi4_w_burst_reader.sv
// Pops AWLEN commands and data beats from two FIFOs and drives a counted
// AXI4 W burst with WLAST; back-to-back bursts run without a bubble.
module axi4_w_burst_reader
    import axi4_w_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned STRB_W = DATA_W / 8,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input logic                  CLK,
    input logic                  RST,
    axi4_w_burst_reader_if.master bus_io
);
    localparam int unsigned    STRB_LSB = dat_strb_lsb(DATA_W);
    localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              cmd_deq_s;
    logic              dat_deq_s;
    logic              beat_s;
    logic              can_load_s;
    logic              w_valid_s;
    logic [DATA_W-1:0] w_data_s;
    logic [STRB_W-1:0] w_strb_s;
    logic              w_last_s;

    // Burst sequencing: accept a command, then count rem down one beat at a time
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cmd_deq_s = 1'b0;
        dat_deq_s = 1'b0;
        beat_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_io.cmd_empty_n) begin
                    cmd_deq_s = 1'b1;
                    rem_d     = bus_io.cmd_len;
                    state_d   = BURST;
                end else begin
                    state_d   = IDLE;
                end
            end
            BURST: begin
                beat_s = bus_io.dat_empty_n && can_load_s;
                if (beat_s) begin
                    dat_deq_s = 1'b1;
                    if (rem_q != {LEN_W{1'b0}}) begin
                        rem_d = rem_q - REM_ONE;
                    end else if (bus_io.cmd_empty_n) begin
                        // Chain the next burst on the last beat of this one
                        cmd_deq_s = 1'b1;
                        rem_d     = bus_io.cmd_len;
                        state_d   = BURST;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = {LEN_W{1'b0}};
            end
        endcase
    end

    // FSM state and beat counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rem_q   <= {LEN_W{1'b0}};
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    axi4_w_out_stage #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_out (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (beat_s),
        .data_i     (bus_io.dat_d[DAT_DATA_LSB +: DATA_W]),
        .strb_i     (bus_io.dat_d[STRB_LSB +: STRB_W]),
        .last_i     (rem_q == {LEN_W{1'b0}}),
        .w_ready_i  (bus_io.w_ready),
        .can_load_o (can_load_s),
        .w_data_o   (w_data_s),
        .w_strb_o   (w_strb_s),
        .w_last_o   (w_last_s),
        .w_valid_o  (w_valid_s)
    );

    assign bus_io.cmd_deq = cmd_deq_s;
    assign bus_io.dat_deq = dat_deq_s;
    assign bus_io.w_data  = w_data_s;
    assign bus_io.w_strb  = w_strb_s;
    assign bus_io.w_last  = w_last_s;
    assign bus_io.w_valid = w_valid_s;
    assign bus_io.busy    = (state_q == BURST) || w_valid_s;
endmodule
